mux_nto1_stream: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake.
- Two select modes:
  - MANUAL: the external `sel` picks the channel.
  - SCAN: an internal round-robin pointer visits each channel for DWELL accepted samples.
- Sits between per-channel sample sources and a single downstream consumer. Replaces the fixed 4-to-1 combinational selector where sources and sinks need flow control.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/mux_scan_ptr.sv | 59 +++++
 rtl/mux_nto1_stream.sv | 116 +++++++++++
 tb/tb_mux_nto1_stream.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 streaming multiplexer.
package mux_pkg;

   typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;
   typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_e;

   // Upper bounds used to give ch_slice a fixed signature; callers zero-pad
   // their packed channel bus up to MAX_CH*MAX_W and keep the low W bits.
   localparam int unsigned MAX_CH = 16;
   localparam int unsigned MAX_W  = 32;

   // Returns channel k of a packed bus whose channels are w bits wide.
   function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_CH*MAX_W-1:0] data,
                                                 input int unsigned k,
                                                 input int unsigned w);
      logic [MAX_CH*MAX_W-1:0] sh;
      sh = data >> (k * w);
      return sh[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin channel pointer for SCAN mode: dwells DWELL captures per
// channel, skips channels with no valid data, wraps N_CH-1 -> 0.
module mux_scan_ptr #(
   parameter int N_CH  = 4,
   parameter int DWELL = 4,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,   // FSM is in SCAN
   input  logic             capture,  // a sample was taken from ptr this cycle
   input  logic             idle,     // slot free but ptr channel has no data
   input  logic             restart,  // entering SCAN: back to channel 0
   output logic [SEL_W-1:0] ptr
);

   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
   localparam logic [7:0]       LAST_CNT = 8'(DWELL - 1);

   logic [SEL_W-1:0] ptr_q, ptr_d, ptr_nxt;
   logic [7:0]       cnt_q, cnt_d;

   assign ptr_nxt = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
   assign ptr     = ptr_q;

   // Next pointer/dwell count; restart wins over any advance on the same edge.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (restart) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (enable) begin
         if (capture) begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               ptr_d = ptr_nxt;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end else if (idle) begin
            cnt_d = '0;
            ptr_d = ptr_nxt;
         end
      end
   end

   // Pointer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel registered multiplexer with valid/ready output, manual or
// round-robin scan selection, and a registered bad-select flag.
module mux_nto1_stream
   import mux_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int W     = 1,
   parameter  int DWELL = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sel_err
);

   localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

   state_e            state_q, state_d;
   mode_e             mode_m;
   logic              restart;
   logic [SEL_W-1:0]  ptr, cur;
   logic              cur_ok, free, capture, idle;
   logic [W-1:0]      out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic              out_valid_q, out_valid_d;
   logic              sel_err_q, sel_err_d;
   logic [MAX_CH*MAX_W-1:0] data_pad;
   logic [MAX_W-1:0]  slice;

   assign mode_m   = mode_e'(mode);
   assign data_pad = (MAX_CH*MAX_W)'(in_data);
   assign slice    = ch_slice(data_pad, int'(cur), W);

   // Mode FSM; restart pulses on the MANUAL -> SCAN edge.
   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      case (state_q)
         ST_MANUAL: if (mode_m == MODE_SCAN) begin
            state_d = ST_SCAN;
            restart = 1'b1;
         end
         ST_SCAN: if (mode_m == MODE_MANUAL) state_d = ST_MANUAL;
         default: state_d = ST_MANUAL;
      endcase
   end

   // Channel choice and handshake qualifiers, all from the current state.
   always_comb begin
      cur     = (state_q == ST_SCAN) ? ptr : sel;
      cur_ok  = {1'b0, cur} < N_CH_L;
      free    = !out_valid_q || out_ready;
      capture = free && cur_ok && in_valid[cur];
      idle    = free && !in_valid[ptr];
   end

   // Output slot next state: load on capture, drain when free, else hold.
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      if (capture) begin
         out_data_d  = slice[W-1:0];
         out_ch_d    = cur;
         out_valid_d = 1'b1;
      end else if (free) begin
         out_valid_d = 1'b0;
      end
      sel_err_d = (state_q == ST_MANUAL) && !cur_ok;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_MANUAL;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   mux_scan_ptr #(
      .N_CH  (N_CH),
      .DWELL (DWELL),
      .SEL_W (SEL_W)
   ) u_scan_ptr (
      .clk     (clk),
      .rst     (rst),
      .enable  (state_q == ST_SCAN),
      .capture (capture),
      .idle    (idle),
      .restart (restart),
      .ptr     (ptr)
   );

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench: 4-channel instance for select/stall/scan, 3-channel
// instance for out-of-range select.
module tb_mux_nto1_stream;

   int total = 0;
   int bad   = 0;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel, 8-bit, DWELL=2
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic        mode = 1'b0;
   logic [1:0]  sel = '0;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid, sel_err;

   // 3-channel, 8-bit, DWELL=2
   logic        rst3 = 1'b1;
   logic [23:0] in_data3 = '0;
   logic [2:0]  in_valid3 = '0;
   logic        mode3 = 1'b0;
   logic [1:0]  sel3 = '0;
   logic        ready3 = 1'b0;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3, sel_err3;

   mux_nto1_stream #(.N_CH(4), .W(8), .DWELL(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .mode(mode),
      .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err));

   mux_nto1_stream #(.N_CH(3), .W(8), .DWELL(2)) dut3 (
      .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .mode(mode3),
      .sel(sel3), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
      .out_ready(ready3), .sel_err(sel_err3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst3 = 1'b1;
      in_data = $urandom; in_valid = 4'($urandom); mode = 1'($urandom);
      sel = 2'($urandom); out_ready = 1'($urandom);
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
      total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
      total++; if (out_valid3 !== 1'b0 || sel_err3 !== 1'b0) begin
         bad++; $display("FAIL reset3 got=%b%b exp=00", out_valid3, sel_err3); end
      mode = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_manual();
      mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h33221100;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         total++; if (out_data !== 8'(s * 8'h11)) begin
            bad++; $display("FAIL manual_data s=%0d got=%h exp=%h", s, out_data, 8'(s * 8'h11)); end
         total++; if (out_ch !== 2'(s) || out_valid !== 1'b1) begin
            bad++; $display("FAIL manual_ch s=%0d got=%0d/%b exp=%0d/1", s, out_ch, out_valid, s); end
      end
   endtask

   task automatic test_stall();
      sel = 2'd1;
      tick();
      total++; if (out_data !== 8'h11) begin bad++; $display("FAIL stall_load got=%h exp=11", out_data); end
      out_ready = 1'b0;
      in_data = 32'h3322AA00;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=11/1", i, out_data, out_valid); end
      end
      out_ready = 1'b1;
      tick();
      total++; if (out_data !== 8'hAA || out_valid !== 1'b1) begin
         bad++; $display("FAIL stall_release got=%h/%b exp=aa/1", out_data, out_valid); end
   endtask

   task automatic test_scan_dwell();
      int exp_ch[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      in_data = 32'h33221100; in_valid = 4'h0; out_ready = 1'b1;
      mode = 1'b1;
      tick();              // MANUAL -> SCAN, pointer restarts at 0
      in_valid = 4'hF;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (out_ch !== 2'(exp_ch[i]) || out_valid !== 1'b1 ||
                      out_data !== 8'(exp_ch[i] * 8'h11)) begin
            bad++; $display("FAIL scan_dwell i=%0d got=%0d/%b/%h exp=%0d/1/%h",
                            i, out_ch, out_valid, out_data, exp_ch[i], 8'(exp_ch[i] * 8'h11)); end
      end
   endtask

   task automatic test_scan_skip();
      // channel 2 is idle: one bubble where the pointer skips it
      int   exp_ch[8] = '{0, 0, 1, 1, 0, 3, 3, 0};
      logic exp_v[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      in_valid = 4'h0; mode = 1'b0;
      tick();
      mode = 1'b1;
      tick();
      in_valid = 4'b1011;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (out_valid !== exp_v[i] || (exp_v[i] && out_ch !== 2'(exp_ch[i]))) begin
            bad++; $display("FAIL scan_skip i=%0d got=%0d/%b exp=%0d/%b",
                            i, out_ch, out_valid, exp_ch[i], exp_v[i]); end
         if (i == 2) begin
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               tick();
               total++; if (out_ch !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
                  bad++; $display("FAIL scan_stall j=%0d got=%0d/%b/%h exp=1/1/11",
                                  j, out_ch, out_valid, out_data); end
            end
            out_ready = 1'b1;
         end
      end
   endtask

   task automatic test_invalid_sel();
      rst3 = 1'b0; mode3 = 1'b0; in_data3 = 24'h221100; in_valid3 = 3'b111;
      ready3 = 1'b1; sel3 = 2'd3;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (sel_err3 !== 1'b1 || out_valid3 !== 1'b0) begin
            bad++; $display("FAIL badsel i=%0d got=%b/%b exp=1/0", i, sel_err3, out_valid3); end
      end
      sel3 = 2'd2;
      tick();
      total++; if (sel_err3 !== 1'b0 || out_valid3 !== 1'b1 || out_data3 !== 8'h22 || out_ch3 !== 2'd2) begin
         bad++; $display("FAIL badsel_recover got=%b/%b/%h/%0d exp=0/1/22/2",
                         sel_err3, out_valid3, out_data3, out_ch3); end
      ready3 = 1'b0; sel3 = 2'd1;
      tick();
      total++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h22) begin
         bad++; $display("FAIL badsel_stall got=%b/%h exp=1/22", out_valid3, out_data3); end
      rst3 = 1'b1;
      tick();
      total++; if (out_valid3 !== 1'b0 || out_data3 !== 8'h00 || sel_err3 !== 1'b0) begin
         bad++; $display("FAIL rst_in_stall got=%b/%h/%b exp=0/00/0", out_valid3, out_data3, sel_err3); end
      // in SCAN the external select is ignored and never flags an error
      rst3 = 1'b0; ready3 = 1'b1; sel3 = 2'd3; mode3 = 1'b1;
      tick();
      tick();
      total++; if (sel_err3 !== 1'b0) begin
         bad++; $display("FAIL scan_sel_err got=%b exp=0", sel_err3); end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_stall();
      test_scan_dwell();
      test_scan_skip();
      test_invalid_sel();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
